// File: rtl/uart_transmitter.sv
// Buffered 8N1 UART transmitter: a byte FIFO feeding a start/data/stop serializer.
// Frames leave back-to-back while the FIFO holds data; the line idles high.
module uart_transmitter #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [7:0]                  data_in,
  input  logic                        data_wr,
  output logic                        fifo_full,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow,
  output logic                        tx_data,
  output logic                        tx_busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [PTR_W:0]   FIFO_MAX = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START_BIT = 2'd1,
    DATA_BITS = 2'd2,
    STOP_BIT  = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count_d;
  logic             wr_en, pop, fifo_empty;

  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_q;
  logic             bit_done, last_bit;

  logic             cnt_run, shift_en, idx_adv, tx_d, busy_d;

  // The full flag is the registered one, so a pop on the same edge cannot rescue a write.
  assign wr_en      = data_wr && !fifo_full;
  assign fifo_empty = (fifo_count == '0);
  assign bit_done   = (bit_cnt == BIT_LAST);
  assign last_bit   = (bit_idx == 3'd7);

  // ---------------------------------------------------------------- FIFO
  // NOTE: every variable driven in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    count_d = fifo_count;
    case ({wr_en, pop})
      2'b10:   count_d = fifo_count + 1'b1;
      2'b01:   count_d = fifo_count - 1'b1;
      default: count_d = fifo_count;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      fifo_full  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= count_d;
      fifo_full  <= (count_d == FIFO_MAX);
      overflow   <= data_wr && fifo_full;
    end
  end

  // NOTE: the storage array is not reset; resetting the pointers and count already empties the FIFO.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= data_in;
  end

  // ---------------------------------------------------------------- FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // ---------------------------------------------------------------- FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (!fifo_empty) state_d = START_BIT;
      START_BIT: if (bit_done) state_d = DATA_BITS;
      DATA_BITS: if (bit_done && last_bit) state_d = STOP_BIT;
      STOP_BIT:  if (bit_done) state_d = fifo_empty ? IDLE : START_BIT;
      default:   state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- FSM outputs
  // tx_d is the next line level; the line itself is registered to stay glitch-free.
  always_comb begin
    pop      = 1'b0;
    shift_en = 1'b0;
    idx_adv  = 1'b0;
    cnt_run  = 1'b1;
    tx_d     = tx_data;
    busy_d   = tx_busy;
    case (state_q)
      IDLE: begin
        cnt_run = 1'b0;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        if (!fifo_empty) begin
          pop    = 1'b1;
          tx_d   = 1'b0;
          busy_d = 1'b1;
        end
      end
      START_BIT: begin
        if (bit_done) tx_d = shift_q[0];
      end
      DATA_BITS: begin
        if (bit_done) begin
          idx_adv = 1'b1;
          if (last_bit) begin
            tx_d = 1'b1;
          end else begin
            tx_d     = shift_q[1];
            shift_en = 1'b1;
          end
        end
      end
      STOP_BIT: begin
        if (bit_done) begin
          if (!fifo_empty) begin
            pop  = 1'b1;
            tx_d = 1'b0;
          end else begin
            tx_d   = 1'b1;
            busy_d = 1'b0;
          end
        end
      end
      default: begin
        cnt_run = 1'b0;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------- serializer datapath
  // The bit counter free-runs across bit boundaries inside a frame and only parks in IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt <= '0;
      bit_idx <= '0;
      shift_q <= '0;
      tx_data <= 1'b1;
      tx_busy <= 1'b0;
    end else begin
      if (!cnt_run)     bit_cnt <= '0;
      else if (bit_done) bit_cnt <= '0;
      else              bit_cnt <= bit_cnt + 1'b1;

      if (pop)          bit_idx <= '0;
      else if (idx_adv) bit_idx <= bit_idx + 1'b1;

      if (pop)           shift_q <= mem[rd_ptr];
      else if (shift_en) shift_q <= {1'b0, shift_q[7:1]};

      tx_data <= tx_d;
      tx_busy <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter: a fast instance (4 clocks/bit, 4-deep FIFO)
// checked cycle by cycle, and a 434 clocks/bit instance checked by a mid-bit UART receiver.
module tb_uart_transmitter;

  localparam int F_CPB   = 4;
  localparam int F_DEPTH = 4;
  localparam int S_CPB   = 434;
  localparam int S_DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;

  logic [7:0] f_din = '0;
  logic       f_wr = 1'b0;
  logic       f_full, f_ovf, f_tx, f_busy;
  logic [2:0] f_count;

  logic [7:0] s_din = '0;
  logic       s_wr = 1'b0;
  logic       s_full, s_ovf, s_tx, s_busy;
  logic [4:0] s_count;

  int checks = 0;
  int errors = 0;

  logic [7:0] f_q[$];
  logic [7:0] s_q[$];

  always #5 clk = ~clk;

  uart_transmitter #(.CLKS_PER_BIT(F_CPB), .FIFO_DEPTH(F_DEPTH)) u_fast (
    .clk(clk), .reset_n(reset_n), .data_in(f_din), .data_wr(f_wr),
    .fifo_full(f_full), .fifo_count(f_count), .overflow(f_ovf),
    .tx_data(f_tx), .tx_busy(f_busy)
  );

  uart_transmitter #(.CLKS_PER_BIT(S_CPB), .FIFO_DEPTH(S_DEPTH)) u_slow (
    .clk(clk), .reset_n(reset_n), .data_in(s_din), .data_wr(s_wr),
    .fifo_full(s_full), .fifo_count(s_count), .overflow(s_ovf),
    .tx_data(s_tx), .tx_busy(s_busy)
  );

  // Samples and drives happen 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expects to be called on the first cycle of a start bit; compares every line cycle
  // with the 8N1 frame built from the next queued byte.
  task automatic watch_frames(input int n);
    logic [7:0] b;
    logic [9:0] bits;
    for (int f = 0; f < n; f++) begin
      check($sformatf("f_frame%0d_queued", f), (f_q.size() > 0), 1'b1);
      if (f_q.size() == 0) return;
      b    = f_q.pop_front();
      bits = {1'b1, b, 1'b0};
      for (int c = 0; c < 10 * F_CPB; c++) begin
        check($sformatf("f_line byte%0h cyc%0d", b, c), f_tx, bits[c / F_CPB]);
        check($sformatf("f_busy byte%0h cyc%0d", b, c), f_busy, 1'b1);
        tick();
      end
    end
  endtask

  // Behavioural UART receiver: finds the start bit, samples each bit mid-way,
  // and measures the stop bit length.
  task automatic s_receive(input int n);
    logic [7:0] decoded, exp_b;
    logic       start_mid;
    int         stop_ones, w;
    for (int f = 0; f < n; f++) begin
      w = 0;
      while (s_tx === 1'b1 && w < 20) begin
        tick();
        w++;
      end
      check($sformatf("s_start_found%0d", f), s_tx, 1'b0);
      if (s_tx !== 1'b0) return;
      decoded   = '0;
      start_mid = 1'b1;
      stop_ones = 0;
      for (int c = 0; c < 10 * S_CPB; c++) begin
        if (c == S_CPB / 2) start_mid = s_tx;
        if (c >= S_CPB && c < 9 * S_CPB && (c % S_CPB) == S_CPB / 2)
          decoded[c / S_CPB - 1] = s_tx;
        if (c >= 9 * S_CPB && s_tx === 1'b1) stop_ones++;
        tick();
      end
      check($sformatf("s_frame%0d_queued", f), (s_q.size() > 0), 1'b1);
      exp_b = (s_q.size() > 0) ? s_q.pop_front() : 8'h00;
      check($sformatf("s_start_mid%0d", f), start_mid, 1'b0);
      check($sformatf("s_byte%0d", f), decoded, exp_b);
      check($sformatf("s_stop_len%0d", f), stop_ones, S_CPB);
      if (f < n - 1) begin
        check($sformatf("s_next_start%0d", f), s_tx, 1'b0);
      end else begin
        check("s_idle_line", s_tx, 1'b1);
        check("s_idle_busy", s_busy, 1'b0);
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] b [1:5];
    logic [7:0] rnd [6];
    int         bad;

    // ---------------- reset values
    repeat (3) tick();
    check("rst_tx", f_tx, 1'b1);
    check("rst_busy", f_busy, 1'b0);
    check("rst_count", f_count, 3'd0);
    check("rst_full", f_full, 1'b0);
    check("rst_ovf", f_ovf, 1'b0);
    check("rst_s_tx", s_tx, 1'b1);
    check("rst_s_count", s_count, 5'd0);
    reset_n = 1'b1;
    repeat (3) tick();
    check("idle_tx", f_tx, 1'b1);

    // ---------------- single byte 0xA5
    f_q.push_back(8'hA5);
    f_din = 8'hA5; f_wr = 1'b1;
    tick();                                     // after E0
    f_wr = 1'b0;
    check("a5_count_e0", f_count, 3'd1);
    check("a5_tx_e0", f_tx, 1'b1);
    tick();                                     // after E1
    check("a5_tx_e1", f_tx, 1'b0);
    check("a5_count_e1", f_count, 3'd0);
    watch_frames(1);
    check("a5_busy_end", f_busy, 1'b0);
    check("a5_tx_end", f_tx, 1'b1);

    // ---------------- back-to-back 0x00, 0xFF, 0x55
    f_q.push_back(8'h00); f_q.push_back(8'hFF); f_q.push_back(8'h55);
    f_din = 8'h00; f_wr = 1'b1;
    tick();
    check("b2b_count_e0", f_count, 3'd1);
    f_din = 8'hFF;
    tick();
    check("b2b_tx_e1", f_tx, 1'b0);
    check("b2b_count_e1", f_count, 3'd1);
    fork
      begin
        f_din = 8'h55;
        tick();
        check("b2b_count_e2", f_count, 3'd2);
        f_wr = 1'b0;
      end
      watch_frames(3);
    join
    check("b2b_busy_end", f_busy, 1'b0);
    check("b2b_tx_end", f_tx, 1'b1);
    check("b2b_count_end", f_count, 3'd0);

    // ---------------- full / overflow / write on the pop edge / pointer wrap
    for (int i = 1; i <= 5; i++) b[i] = 8'($urandom);
    f_q.push_back(8'h3C);
    for (int i = 1; i <= 4; i++) f_q.push_back(b[i]);
    f_din = 8'h3C; f_wr = 1'b1;
    tick();                                     // after E0
    f_din = b[1];
    tick();                                     // after E1: pop + write
    check("ovf_count_e1", f_count, 3'd1);
    fork
      begin
        for (int i = 2; i <= 5; i++) begin
          f_din = b[i];
          tick();
          if (i == 4) begin
            check("ovf_full_e4", f_full, 1'b1);
            check("ovf_count_e4", f_count, 3'd4);
            check("ovf_quiet_e4", f_ovf, 1'b0);
          end
        end
        check("ovf_pulse_e5", f_ovf, 1'b1);
        check("ovf_count_e5", f_count, 3'd4);
        check("ovf_full_e5", f_full, 1'b1);
        f_wr = 1'b0;
        tick();
        check("ovf_drop_e6", f_ovf, 1'b0);
        repeat (34) tick();                     // after E40
        f_din = 8'hEE; f_wr = 1'b1;
        tick();                                 // after E41: pop edge, write dropped
        f_wr = 1'b0;
        check("popfull_ovf", f_ovf, 1'b1);
        check("popfull_count", f_count, 3'd3);
        check("popfull_full", f_full, 1'b0);
        tick();
        check("popfull_ovf_clear", f_ovf, 1'b0);
        repeat (78) tick();                     // after E120
        check("wrap_count_pre", f_count, 3'd2);
        f_q.push_back(8'h96);
        f_din = 8'h96; f_wr = 1'b1;
        tick();                                 // after E121: pop + write
        f_wr = 1'b0;
        check("wrap_count_post", f_count, 3'd2);
      end
      watch_frames(6);
    join
    check("ovf_busy_end", f_busy, 1'b0);
    check("ovf_count_end", f_count, 3'd0);
    bad = 0;
    repeat (2 * 10 * F_CPB) begin
      if (f_tx !== 1'b1 || f_busy !== 1'b0) bad++;
      tick();
    end
    check("ovf_no_extra_frame", bad, 0);

    // ---------------- reset mid-frame
    f_din = 8'h81; f_wr = 1'b1;
    tick();
    f_din = 8'h7E;
    tick();
    f_wr = 1'b0;
    repeat (15) tick();
    check("mid_busy_before", f_busy, 1'b1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_tx", f_tx, 1'b1);
    check("mid_rst_busy", f_busy, 1'b0);
    check("mid_rst_count", f_count, 3'd0);
    check("mid_rst_full", f_full, 1'b0);
    repeat (2) tick();
    reset_n = 1'b1;
    bad = 0;
    repeat (60) begin
      tick();
      if (f_tx !== 1'b1 || f_busy !== 1'b0 || f_count !== 3'd0) bad++;
    end
    check("mid_rst_idle_after", bad, 0);

    // ---------------- random bytes at 434 clocks per bit
    for (int i = 0; i < 6; i++) begin
      rnd[i] = 8'($urandom);
      s_q.push_back(rnd[i]);
    end
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          s_din = rnd[i]; s_wr = 1'b1;
          tick();
        end
        s_wr = 1'b0;
      end
      s_receive(6);
    join
    check("s_count_end", s_count, 5'd0);
    check("s_ovf_end", s_ovf, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

Buffered UART transmitter for 8N1 serial frames. It is the transmit-side counterpart of the board's UART receive path and drives the TX pin at the same baud setting, so a host link can echo or send status bytes. A small byte FIFO decouples fabric writers from the serial line. Frames go out back-to-back while the FIFO holds data.

## Interface
- CLKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200); legal range ≥ 2
- FIFO_DEPTH, 16, byte FIFO entries; power of two, ≥ 2
- clk  input  1  board clock; all logic on rising edge
- reset_n  input  1  asynchronous, active-low reset
- data_in  input  8  byte to enqueue
- data_wr  input  1  write strobe; one byte enqueued per cycle high
- fifo_full  output  1  FIFO holds FIFO_DEPTH bytes
- fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes currently queued (excludes byte on the line)
- overflow  output  1  one-cycle pulse when a write is dropped
- tx_data  output  1  serial line, idle high
- tx_busy  output  1  high while a frame is on the line

## Operation
- Reset (asynchronous, immediate): tx_data=1, tx_busy=0, fifo_full=0, fifo_count=0, overflow=0, FIFO flushed, FSM=IDLE, bit counter and index cleared. Reset mid-frame aborts the frame; the line returns high at once.
- FIFO write: data_wr=1 and fifo_full=0 at an edge stores data_in and increments count. data_wr=1 while fifo_full=1 drops the byte and pulses overflow the next cycle. fifo_full is evaluated before the edge, so a pop in the same cycle does not rescue the write.
- Simultaneous write (not full) and pop: count unchanged, both pointers advance, and pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START_BIT, DATA_BITS, STOP_BIT.
- IDLE: tx_data=1. If FIFO is non-empty, pop the head into the shift register, tx_data<=0, tx_busy<=1, and go to START_BIT.
- START_BIT: hold 0 for CLKS_PER_BIT cycles, then drive bit 0 and go to DATA_BITS.
- DATA_BITS: bits sent LSB first, each held CLKS_PER_BIT cycles. After bit 7, drive 1 and go to STOP_BIT.
- STOP_BIT: hold 1 for CLKS_PER_BIT cycles. At the end:
  - If the FIFO is non-empty, pop, drive 0, and go directly to START_BIT (no idle gap).
  - Otherwise, tx_busy<=0 and go to IDLE.
- Bit counter width is $clog2(CLKS_PER_BIT); it counts 0..CLKS_PER_BIT-1 and wraps. The counter is not reset between bits within a frame.
- The byte on the line is latched at pop. FIFO writes never alter the frame in progress.
- Illegal state encodings go to IDLE with tx_data=1.

## Timing
- Write at edge E0 into an empty FIFO with FSM idle: count=1 after E0. At E1 the pop occurs, and tx_data falls after E1, with count=0.
- Frame length is exactly 10*CLKS_PER_BIT cycles: start, 8 data bits, stop. Every bit boundary is exactly CLKS_PER_BIT cycles after the previous one.
- Back-to-back frames: the next start bit falls exactly 10*CLKS_PER_BIT cycles after the previous start bit.
- tx_busy rises with the start-bit edge. It falls on the edge that ends the last stop bit.
- fifo_count and fifo_full are registered and reflect the edge just taken. overflow is a registered one-cycle pulse.

## Test plan
- Reset values: assert reset_n=0 mid-frame (CLKS_PER_BIT=4) -> tx_data=1 immediately, tx_busy=0, fifo_count=0. After release, the line stays idle with no spurious frame.
- Single byte: write 0xA5 with CLKS_PER_BIT=4 -> tx_data falls 2 edges after the write. Line reads 0,1,0,1,0,0,1,0,1,1 at 4 cycles per bit. tx_busy is high for 40 cycles.
- Back-to-back: write 0x00, 0xFF, 0x55 on consecutive cycles -> three frames with start bits exactly 40 cycles apart and no idle gap. tx_busy stays high for 120 cycles.
- Full/overflow: FIFO_DEPTH=4 while a frame is sending; write 5 bytes -> after 4, fifo_full=1 and fifo_count=4. The 5th write pulses overflow for 1 cycle and is never transmitted.
- Write during pop: with FIFO full and data_wr=1 on the pop edge -> write dropped, overflow pulses, count becomes 3. With count=2 and a write on the pop edge -> count stays 2, and the byte order on the line is preserved across pointer wrap.
- Stop-bit integrity: random bytes at CLKS_PER_BIT=434 -> the receive path decodes every byte correctly, and each stop bit is exactly 434 cycles.
